// File: rtl/sap_ctrl_pkg.sv
// Shared defaults, T-state width and FSM state encoding for the control sequencer.
// No logic; no latency; no flow control.
package sap_ctrl_pkg;
    localparam int CW_WIDTH_DEF = 18;
    localparam int T_LAST_DEF   = 4;
    localparam int HLT_BIT_DEF  = 17;
    localparam int T_W          = 3;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;
endpackage

// File: rtl/control_sequencer_if.sv
// Opcode/microcode/step inputs and sequencer outputs bundled between core and datapath.
// Pure wiring; zero latency; no backpressure (step is a level request).
interface control_sequencer_if
    import sap_ctrl_pkg::*;
#(
    parameter int CW_WIDTH = CW_WIDTH_DEF
);
    logic [3:0]          Opcode;
    logic [CW_WIDTH-1:0] Ctrl_Word;
    logic                Run_Mode;
    logic                Step;
    logic [6:0]          Rom_Address;
    logic [CW_WIDTH-1:0] Control_Out;
    logic [T_W-1:0]      T_State;
    logic                Halted;
    logic                Instr_Start;

    modport master (
        output Opcode, Ctrl_Word, Run_Mode, Step,
        input  Rom_Address, Control_Out, T_State, Halted, Instr_Start
    );

    modport slave (
        input  Opcode, Ctrl_Word, Run_Mode, Step,
        output Rom_Address, Control_Out, T_State, Halted, Instr_Start
    );
endinterface

// File: rtl/control_sequencer_step_pulse.sv
// Registers the manual step level and flags its rising edge.
// Edge flag is combinational against a one-cycle-old copy; no backpressure.
module step_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    output logic step_rise
);
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
endmodule

// File: rtl/control_sequencer.sv
// Microcode T-state sequencer with HLT and single-step; optional EARLY_END_EN ends an instruction on a zero word.
// Control_Out/Instr_Start zero-latency from inputs; T_State/Halted registered; Step held high advances once.
module control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int CW_WIDTH = CW_WIDTH_DEF,
    parameter int T_LAST   = T_LAST_DEF,
    parameter int HLT_BIT  = HLT_BIT_DEF
) (
    input logic               CLK,
    input logic               RESET_n,
    control_sequencer_if.slave bus
);
    localparam logic [T_W-1:0] T_LAST_V = T_W'(T_LAST);

    state_t         state;
    logic [T_W-1:0] t_state;
    logic           halted;
    logic           step_rise;
    logic           advance;
    logic           hlt;
    logic           early_end;

    step_pulse u_step_pulse (
        .clk       (CLK),
        .rst_n     (RESET_n),
        .step      (bus.Step),
        .step_rise (step_rise)
    );

    // RESET_n gates the comb outputs so nothing leaks to the datapath during reset.
    assign advance = RESET_n && (state == S_RUN) && (bus.Run_Mode || step_rise);
    assign hlt     = bus.Ctrl_Word[HLT_BIT];

`ifdef EARLY_END_EN
    assign early_end = (t_state >= T_W'(2)) && (bus.Ctrl_Word == {CW_WIDTH{1'b0}});
`else
    assign early_end = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= S_RUN;
            t_state <= '0;
            halted  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (advance) begin
                        // HLT wins over early end; T_State freezes where it stopped.
                        if (hlt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else if (early_end || (t_state == T_LAST_V)) begin
                            t_state <= '0;
                        end else begin
                            t_state <= t_state + T_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Rom_Address = {bus.Opcode, t_state};
    assign bus.Control_Out = advance ? bus.Ctrl_Word : {CW_WIDTH{1'b0}};
    assign bus.T_State     = t_state;
    assign bus.Halted      = halted;
    assign bus.Instr_Start = advance && (t_state == '0);
endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: stimulus queues per-cycle expectations, negedge monitor compares.
// Expected T-state sequences and gating are hand-derived; EARLY_END_EN selects the matching table.
module tb_control_sequencer;
    import sap_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RESET_n;
    always #5 CLK = ~CLK;

    control_sequencer_if #(.CW_WIDTH(18)) bus ();

    control_sequencer dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    logic [17:0] rom [128];
    assign bus.Ctrl_Word = rom[bus.Rom_Address];

    typedef struct {
        int          id;
        logic [2:0]  t;
        logic [17:0] cout;
        logic        h;
        logic        is;
        logic [6:0]  addr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rec    = 0;

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (bus.T_State !== mon_e.t || bus.Control_Out !== mon_e.cout ||
                bus.Halted !== mon_e.h || bus.Instr_Start !== mon_e.is ||
                bus.Rom_Address !== mon_e.addr) begin
                errors++;
                $display("FAIL cycle_rec %0d: got t=%0d cout=%h halted=%b istart=%b addr=%h, want t=%0d cout=%h halted=%b istart=%b addr=%h",
                         mon_e.id, bus.T_State, bus.Control_Out, bus.Halted, bus.Instr_Start, bus.Rom_Address,
                         mon_e.t, mon_e.cout, mon_e.h, mon_e.is, mon_e.addr);
            end
        end
    end

    // Queue the expectation for the current cycle, then move to just after the next rising edge.
    task automatic cyc(input int t, input bit adv, input bit h);
        exp_t e;
        e.id   = rec;
        rec++;
        e.t    = 3'(t);
        e.addr = {bus.Opcode, 3'(t)};
        e.cout = adv ? rom[{bus.Opcode, 3'(t)}] : 18'h0;
        e.h    = h;
        e.is   = adv && (t == 0);
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 18'h0;
        rom[1*8+0] = 18'h00111; rom[1*8+1] = 18'h00222; rom[1*8+2] = 18'h00333;
        rom[1*8+3] = 18'h00444; rom[1*8+4] = 18'h00555;
        rom[2*8+0] = 18'h01001; rom[2*8+1] = 18'h01002;
        rom[3*8+0] = 18'h02001; rom[3*8+1] = 18'h02002; rom[3*8+2] = 18'h02003;
        rom[3*8+3] = 18'h02004;
        rom[15*8+0] = 18'h0F001; rom[15*8+1] = 18'h0F002; rom[15*8+2] = 18'h20000;
        rom[15*8+3] = 18'h0F004; rom[15*8+4] = 18'h0F005;

        RESET_n      = 1'b0;
        bus.Run_Mode = 1'b1;
        bus.Step     = 1'b1;
        bus.Opcode   = 4'd1;
        @(posedge CLK);
        #1;
        cyc(0, 0, 0);

        // Free run: two full instructions start, then reset lands while at T3.
        RESET_n = 1'b1;
        cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0); cyc(4, 1, 0);
        cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0);
        RESET_n      = 1'b0;
        bus.Run_Mode = 1'b0;
        bus.Step     = 1'b0;
        cyc(0, 0, 0);

        // Single-step: held Step advances once, a fresh edge advances again.
        RESET_n = 1'b1;
        cyc(0, 0, 0);
        bus.Step = 1'b1;
        cyc(0, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        bus.Step = 1'b0;
        cyc(1, 0, 0);
        bus.Step = 1'b1;
        cyc(1, 1, 0);
        bus.Step = 1'b0;
        cyc(2, 0, 0);
        bus.Run_Mode = 1'b1;
        cyc(2, 1, 0); cyc(3, 1, 0); cyc(4, 1, 0);

        // Zero words at T2..T4.
        bus.Opcode = 4'd2;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0);
`ifndef EARLY_END_EN
            cyc(3, 1, 0); cyc(4, 1, 0);
`endif
        end

        // Zero word only at T4: wraps identically either way.
        bus.Opcode = 4'd3;
        cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0); cyc(4, 1, 0);

        // HLT at T2, then halted with Step and Run_Mode wiggling.
        bus.Opcode = 4'd15;
        cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0);
        for (int i = 0; i < 20; i++) begin
            bus.Step     = i[0];
            bus.Run_Mode = i[1];
            cyc(2, 0, 1);
        end
        RESET_n  = 1'b0;
        bus.Step = 1'b0;
        cyc(0, 0, 0);
        RESET_n      = 1'b1;
        bus.Run_Mode = 1'b1;
        bus.Opcode   = 4'd1;
        cyc(0, 1, 0); cyc(1, 1, 0);

        @(posedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
